// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, legal
// oversampling ratios and the default payload width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic [5:0] PRESCALE_X8  = 6'd8;
  localparam logic [5:0] PRESCALE_X16 = 6'd16;
  localparam logic [5:0] PRESCALE_X32 = 6'd32;

  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for uart_rx: edge/bit counters and the per-bit line decision.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit instead of one sample.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       frame_start,
  input  logic       frame_active,
  input  logic       in_data,
  input  logic [5:0] prescale,
  output logic       bit_val,
  output logic       bit_end,
  output logic       ctl_tick,
  output logic       last_data_bit
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [5:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bit_q, bit_d;
  logic [5:0]       half;

  assign half          = {1'b0, prescale[5:1]};
  assign bit_end       = frame_active && (edge_cnt_q == prescale - 6'd1);
  assign ctl_tick      = frame_active && (edge_cnt_q == prescale - 6'd2);
  assign last_data_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign bit_val       = bit_q;

`ifdef UART_RX_MAJORITY_EN
  logic s0_q, s0_d, s1_q, s1_d;
`endif

  // The start-detect cycle itself is edge 0 of the start bit, so counting resumes at 1.
  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    bit_d      = bit_q;
`ifdef UART_RX_MAJORITY_EN
    s0_d       = s0_q;
    s1_d       = s1_q;
`endif
    if (frame_start) begin
      edge_cnt_d = 6'd1;
    end else if (frame_active) begin
      edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
    end

    if (!in_data) begin
      bit_cnt_d = '0;
    end else if (bit_end) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (frame_active) begin
`ifdef UART_RX_MAJORITY_EN
      if (edge_cnt_q == half - 6'd1) s0_d = rx_in;
      if (edge_cnt_q == half)        s1_d = rx_in;
      if (edge_cnt_q == half + 6'd1) bit_d = majority3(s0_q, s1_q, rx_in);
`else
      if (edge_cnt_q == half) bit_d = rx_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      bit_q      <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
`endif
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_q      <= bit_d;
`ifdef UART_RX_MAJORITY_EN
      s0_q       <= s0_d;
      s1_q       <= s1_d;
`endif
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserialiser, parity and stop checks.
// Bit decisions come from uart_rx_sampler (UART_RX_MAJORITY_EN selects voting).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  Par_EN,
  input  logic                  Par_type,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  uart_state_e           state_q, state_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic frame_start, bit_val, bit_end, ctl_tick, last_data_bit, exp_par;

  assign frame_start = (state_q == IDLE) && !RX_IN;
  assign exp_par     = par_type_q ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(.DATA_WIDTH(DATA_WIDTH)) u_sampler (
    .clk           (CLK),
    .rst           (RST),
    .rx_in         (RX_IN),
    .frame_start   (frame_start),
    .frame_active  (state_q != IDLE),
    .in_data       (state_q == DATA),
    .prescale      (prescale_q),
    .bit_val       (bit_val),
    .bit_end       (bit_end),
    .ctl_tick      (ctl_tick),
    .last_data_bit (last_data_bit)
  );

  // Pulses are registered one edge early (ctl_tick) so they appear on the last cycle of the bit.
  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    par_fail_d   = par_fail_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d    = START;
          prescale_d = Prescale;
          par_en_d   = Par_EN;
          par_type_d = Par_type;
          par_fail_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (last_data_bit) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (ctl_tick && (bit_val != exp_par)) begin
          par_err_d  = 1'b1;
          par_fail_d = 1'b1;
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (ctl_tick) begin
          if (!bit_val) begin
            stp_err_d = 1'b1;
          end else if (!par_fail_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      prescale_q   <= PRESCALE_X8;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_fail_q   <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      par_fail_q   <= par_fail_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_Data     = p_data_q;
  assign Data_valid = data_valid_q;
  assign Par_err    = par_err_q;
  assign Stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port CLK  input  1  receive clock, oversampled relative to the bit rate.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port RX_IN  input  1  serial line, idle high; already synchronised upstream.
REQ-005 SHALL have port Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-006 SHALL have port Par_EN  input  1  parity bit present in the frame.
REQ-007 SHALL have port Par_type  input  1  parity type: 0 even, 1 odd.
REQ-008 SHALL have port P_Data  output  DATA_WIDTH  received payload.
REQ-009 SHALL have port Data_valid  output  1  one-cycle pulse; P_Data holds a good frame.
REQ-010 SHALL have port Par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port Stp_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL move from IDLE to START on the first CLK on which RX_IN is 0; Prescale, Par_EN and Par_type SHALL be latched on that same edge and held for the whole frame.
REQ-014 SHALL count CLKs within each bit with edge_cnt, 0..Prescale-1, and count bits with bit_cnt.
REQ-015 SHALL sample each bit at edge_cnt = Prescale/2; the bit decision SHALL be available at edge_cnt = Prescale/2+1.
REQ-016 In START, a sampled 1 (glitch) SHALL return the FSM to IDLE at the end of the bit, with no output pulse.
REQ-017 DATA SHALL shift DATA_WIDTH bits in LSB first, then go to PARITY if Par_EN=1, otherwise to STOP.
REQ-018 PARITY SHALL compare the sampled bit with ^data (even) or ~^data (odd); on mismatch, Par_err SHALL pulse at edge_cnt = Prescale-1 and the FSM SHALL still proceed to STOP.
REQ-019 STOP, at edge_cnt = Prescale-1, SHALL pulse Data_valid and update P_Data only if the stop bit = 1 and no parity error occurred in the frame; if the stop bit = 0, Stp_err SHALL pulse instead.
REQ-020 After STOP the FSM SHALL go to IDLE; if RX_IN = 0 on the first IDLE cycle, that cycle SHALL count as the start edge (back-to-back frames, zero gap).
REQ-021 P_Data SHALL hold its last good value until the next good frame.
REQ-022 Data_valid latency SHALL be (10 + Par_EN) × Prescale CLKs, measured from the start edge to the pulse cycle, inclusive.
REQ-023 Changes on Prescale, Par_EN or Par_type mid-frame SHALL have no effect on the current frame.

Reset
REQ-024 RST=1 SHALL force IDLE, clear both counters and the shift register, and drive P_Data=0, Data_valid=0, Par_err=0, Stp_err=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no pulse SHALL be issued after release.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN defined: each bit SHALL be the 2-of-3 majority of samples at edge_cnt Prescale/2-1, Prescale/2 and Prescale/2+1, with the decision at Prescale/2+2.
REQ-027 Macro UART_RX_MAJORITY_EN undefined: each bit SHALL use the single sample of REQ-015; frame timing and latency SHALL be identical in both builds.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state enum, the legal Prescale constants (8/16/32) and the default DATA_WIDTH.
REQ-029 One sub-module, uart_rx_sampler, SHALL hold edge_cnt, bit_cnt and the sample/majority logic; uart_rx SHALL hold the FSM, the deserialiser and the checks.

Verification
REQ-030 Prescale=8, Par_EN=1, Par_type=0, frame 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) -> Data_valid pulse 88 CLKs after the start edge, P_Data=0xA5, no errors.
REQ-031 Prescale=16, Par_EN=0, byte 0x3C -> Data_valid at 160 CLKs, P_Data=0x3C; then 0x81 sent back-to-back -> second pulse 160 CLKs later, P_Data=0x81.
REQ-032 Prescale=8, Par_EN=1, Par_type=1 with parity bit forced to 0 for 0xA5 -> Par_err single pulse, no Data_valid, P_Data keeps its previous value.
REQ-033 Stop bit driven 0 -> Stp_err pulse at the end of the stop bit, no Data_valid; RX_IN low 3 CLKs only (Prescale=8) -> return to IDLE, no pulses.
REQ-034 RST asserted during the DATA state of 0x5A, then released, then a clean 0x0F frame -> no pulse for 0x5A, Data_valid with P_Data=0x0F.
REQ-035 UART_RX_MAJORITY_EN defined, one-CLK low glitch at edge_cnt=Prescale/2 on data bit 0 of 0xFF -> P_Data=0xFF; with the macro undefined -> P_Data=0xFE.
